pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the 8-bit program counter of the 19-bit, 4-stage CPU (IF, ID, EX, WB).
- Each cycle it chooses the next fetch address from these sources:
  - sequential increment,
  - EX-stage jump, branch or call target,
  - the top of an internal return-address stack (RAS) for ret.
- It drives flush to squash the IF/ID instructions younger than a taken redirect, and honours hazard stalls.

Parameters:
- AW, 8, instruction address width.
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hazard unit: hold PC (IF/ID frozen)
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction
- j  in  1  EX opcode is jump
- beq  in  1  EX opcode is branch-if-equal
- bne  in  1  EX opcode is branch-if-not-equal
- call  in  1  EX opcode is call
- ret  in  1  EX opcode is return
- eq  in  1  EX operand compare, r1_data == r3_data
- target  in  AW  EX immediate target address
- ex_pc  in  AW  PC of the EX instruction
- pc  out  AW  current fetch address (registered)
- flush  out  1  kill the IF and ID instructions this cycle (combinational)
- ras_empty  out  1  stack holds no entries
- ras_full  out  1  stack holds RAS_DEPTH entries
- err  out  1  sticky: illegal control combination, RAS overflow or RAS underflow

Behaviour:
- Reset (async, rst=1): pc=0, RAS pointer=0, ras_empty=1, ras_full=0, err=0. flush=0 while rst is high.
- Control decode applies only when ex_valid=1. With ex_valid=0 every control input is ignored.
- Exactly one of j/beq/bne/call/ret may be high. If more than one is high: no redirect, no RAS change, err←1.
- Redirect cases, all same-cycle decisions:
  - j: redirect to target.
  - beq & eq: redirect to target. beq & ~eq: not taken.
  - bne & ~eq: redirect to target. bne & eq: not taken.
  - call: redirect to target. Push ex_pc+1 (mod 2^AW).
  - ret with RAS non-empty: redirect to the popped top entry.
  - ret with RAS empty: no redirect, no pop, err←1.
- call when full: redirect still taken. Push dropped, stack contents unchanged, err←1.
- flush = redirect. It is combinational, so the IF/ID registers clear on the same edge at which pc loads the new address. Redirect penalty is exactly 2 bubbles.
- PC update on each rising edge, in priority order:
  1. redirect → next address,
  2. stall → hold,
  3. otherwise → pc+1.
- PC wraps 8'hFF → 8'h00. The wrap is silent and does not set err.
- Redirect overrides stall: the stalled younger instructions are wrong-path anyway.
- RAS is LIFO and changes only on the clock edge. A push and a pop can never occur in the same cycle because the controls are one-hot.
- ras_empty and ras_full are decoded from the registered pointer.
- err is cleared only by rst.
- Reset asserted mid-operation: all state returns to reset values immediately. The RAS contents array need not be cleared, because the pointer reset makes it unreachable.

Decomposition:
- Shared package cpu_pkg:
  - AW constant,
  - redirect-cause encoding (NONE, JMP, BEQ, BNE, CALL, RET) used for debug/trace,
  - RAS_DEPTH default.
- One sub-module, ras_stack: clk, rst, push, pop, din, dout (the top entry), empty, full. It has a pointer of $clog2(RAS_DEPTH)+1 bits.
- pc_sequencer keeps the decode, the priority mux, the PC register and the err logic.

Test Plan:
- Reset, then 3 cycles with no controls → pc goes 0,1,2,3; flush=0 throughout.
- pc=8'h14, EX: j=1, target=8'h40, ex_valid=1 → flush=1 that cycle, pc=8'h40 next edge, then 8'h41.
- beq=1, eq=0, target=8'h20 → no flush, pc increments. Then bne=1, eq=0, target=8'h20 → flush, pc=8'h20.
- call (ex_pc=8'h10, target=8'h80), then later ret → pc=8'h80 after the call. After ret, pc=8'h11 and ras_empty=1.
- 5 nested calls with RAS_DEPTH=4 → err=1 at the 5th call, ras_full=1. Then 4 rets return, in order, ex_pc+1 of calls 4,3,2,1. A 5th ret sets no redirect and pc increments.
- Stall=1 with j=1 in the same cycle → redirect wins. Stall with no control → pc holds. ex_valid=0 with j=1 → ignored. j=1 and call=1 together → err=1, pc increments. rst pulsed mid-run → pc=0, err=0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 4-stage CPU front end.
// Holds the instruction address width, RAS depth default and redirect-cause encoding.
package cpu_pkg;

    localparam int AW        = 8;
    localparam int RAS_DEPTH = 4;

    // Why the PC was redirected this cycle; kept for debug/trace visibility.
    typedef enum logic [2:0] {
        CAUSE_NONE = 3'd0,
        CAUSE_JMP  = 3'd1,
        CAUSE_BEQ  = 3'd2,
        CAUSE_BNE  = 3'd3,
        CAUSE_CALL = 3'd4,
        CAUSE_RET  = 3'd5
    } redirect_cause_e;

endpackage

// File: rtl/ras_stack.sv
// LIFO return-address stack with a registered occupancy pointer.
// The pointer carries one extra bit so that the full state is distinct from the empty state.
module ras_stack #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] FULL_PTR = PW'(DEPTH);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [IW-1:0] top_idx;
    logic          push_ok, pop_ok;

    assign empty   = (ptr_q == '0);
    assign full    = (ptr_q == FULL_PTR);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign top_idx = IW'(ptr_q - 1'b1);
    assign dout    = mem_q[top_idx];

    always_comb begin
        ptr_d = ptr_q;
        if (push_ok) begin
            ptr_d = ptr_q + 1'b1;
        end else if (pop_ok) begin
            ptr_d = ptr_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Contents are not reset: a zero pointer leaves every entry unreachable.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[ptr_q[IW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: picks the next fetch address from increment, EX target or RAS.
// Drives a combinational flush on taken redirects and holds the PC on hazard stalls.
module pc_sequencer #(
    parameter int AW        = cpu_pkg::AW,
    parameter int RAS_DEPTH = cpu_pkg::RAS_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          ex_valid,
    input  logic          j,
    input  logic          beq,
    input  logic          bne,
    input  logic          call,
    input  logic          ret,
    input  logic          eq,
    input  logic [AW-1:0] target,
    input  logic [AW-1:0] ex_pc,
    output logic [AW-1:0] pc,
    output logic          flush,
    output logic          ras_empty,
    output logic          ras_full,
    output logic          err
);

    import cpu_pkg::*;

    logic [AW-1:0]   pc_q, pc_d;
    logic            err_q, err_d;
    logic [AW-1:0]   ras_dout;
    logic [AW-1:0]   ret_addr;
    logic [AW-1:0]   next_addr;
    logic            ras_push, ras_pop;
    logic            one_hot, illegal;
    logic            redirect;
    redirect_cause_e cause;

    assign ret_addr = ex_pc + 1'b1;

    ras_stack #(
        .DW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (ret_addr),
        .dout  (ras_dout),
        .empty (ras_empty),
        .full  (ras_full)
    );

    always_comb begin
        one_hot   = ex_valid && ($countones({j, beq, bne, call, ret}) == 1);
        illegal   = ex_valid && ($countones({j, beq, bne, call, ret}) > 1);
        cause     = CAUSE_NONE;
        next_addr = target;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        err_d     = err_q || illegal;

        if (one_hot) begin
            if (j) begin
                cause = CAUSE_JMP;
            end else if (beq && eq) begin
                cause = CAUSE_BEQ;
            end else if (bne && !eq) begin
                cause = CAUSE_BNE;
            end else if (call) begin
                // A call on a full stack still redirects; only the push is lost.
                cause    = CAUSE_CALL;
                ras_push = !ras_full;
                err_d    = err_q || ras_full;
            end else if (ret) begin
                if (ras_empty) begin
                    err_d = 1'b1;
                end else begin
                    cause     = CAUSE_RET;
                    ras_pop   = 1'b1;
                    next_addr = ras_dout;
                end
            end
        end

        redirect = (cause != CAUSE_NONE);

        if (redirect) begin
            pc_d = next_addr;
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign pc    = pc_q;
    assign err   = err_q;
    assign flush = redirect && !rst;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table with a scoreboard queue of expected
// post-edge state, plus hand-written reset sequences.
module tb_pc_sequencer;

    localparam int AW = 8;

    typedef struct {
        logic          st;
        logic          ev;
        logic [4:0]    ctl;   // {j, beq, bne, call, ret}
        logic          eq;
        logic [AW-1:0] tgt;
        logic [AW-1:0] epc;
        logic          fl;
        logic [AW-1:0] pc;
        logic          err;
        logic          emp;
        logic          full;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, ex_valid, j, beq, bne, call, ret, eq;
    logic [AW-1:0] target, ex_pc;
    logic [AW-1:0] pc;
    logic          flush, ras_empty, ras_full, err;

    int   n_applied = 0;
    int   n_miss    = 0;
    vec_t tab_a[$];
    vec_t tab_b[$];
    vec_t sb[$];

    pc_sequencer #(.AW(AW), .RAS_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .ex_valid  (ex_valid),
        .j         (j),
        .beq       (beq),
        .bne       (bne),
        .call      (call),
        .ret       (ret),
        .eq        (eq),
        .target    (target),
        .ex_pc     (ex_pc),
        .pc        (pc),
        .flush     (flush),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic st, logic ev, logic [4:0] ctl, logic e,
                                logic [AW-1:0] tg, logic [AW-1:0] ep, logic fl,
                                logic [AW-1:0] p, logic er, logic em, logic fu);
        vec_t v;
        v.st = st; v.ev = ev; v.ctl = ctl; v.eq = e; v.tgt = tg; v.epc = ep;
        v.fl = fl; v.pc = p; v.err = er; v.emp = em; v.full = fu;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_applied++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic ev, input logic [4:0] ctl,
                         input logic e, input logic [AW-1:0] tg, input logic [AW-1:0] ep);
        stall = st; ex_valid = ev;
        {j, beq, bne, call, ret} = ctl;
        eq = e; target = tg; ex_pc = ep;
    endtask

    // Drive one vector just after an edge, check flush mid-cycle, check state after the edge.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        drive(v.st, v.ev, v.ctl, v.eq, v.tgt, v.epc);
        #1;
        chk($sformatf("flush[%0d]", idx), int'(flush), int'(v.fl));
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("sb_empty[%0d]", idx), 0, 1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("pc[%0d]", idx),    int'(pc),        int'(e.pc));
            chk($sformatf("err[%0d]", idx),   int'(err),       int'(e.err));
            chk($sformatf("empty[%0d]", idx), int'(ras_empty), int'(e.emp));
            chk($sformatf("full[%0d]", idx),  int'(ras_full),  int'(e.full));
        end
    endtask

    localparam logic [4:0] NO = 5'b00000, J = 5'b10000, BQ = 5'b01000,
                           BN = 5'b00100, CL = 5'b00010, RT = 5'b00001;

    initial begin
        // st ev ctl eq tgt epc | fl pc err emp full
        tab_a.push_back(mk(0,0,NO,0,8'h00,8'h00, 0,8'h01,0,1,0));
        tab_a.push_back(mk(0,0,NO,0,8'h00,8'h00, 0,8'h02,0,1,0));
        tab_a.push_back(mk(0,0,NO,0,8'h00,8'h00, 0,8'h03,0,1,0));
        tab_a.push_back(mk(0,1,J ,0,8'hFE,8'h00, 1,8'hFE,0,1,0));
        tab_a.push_back(mk(0,0,NO,0,8'h00,8'h00, 0,8'hFF,0,1,0));
        tab_a.push_back(mk(0,0,NO,0,8'h00,8'h00, 0,8'h00,0,1,0));
        tab_a.push_back(mk(0,1,J ,0,8'h14,8'h00, 1,8'h14,0,1,0));
        tab_a.push_back(mk(0,1,J ,0,8'h40,8'h12,1,8'h40,0,1,0));
        tab_a.push_back(mk(0,0,NO,0,8'h00,8'h00, 0,8'h41,0,1,0));
        tab_a.push_back(mk(0,1,BQ,0,8'h20,8'h3F, 0,8'h42,0,1,0));
        tab_a.push_back(mk(0,1,BN,0,8'h20,8'h40, 1,8'h20,0,1,0));
        tab_a.push_back(mk(0,1,BQ,1,8'h30,8'h1E, 1,8'h30,0,1,0));
        tab_a.push_back(mk(0,1,BN,1,8'h50,8'h2E, 0,8'h31,0,1,0));
        tab_a.push_back(mk(0,1,CL,0,8'h80,8'h10, 1,8'h80,0,0,0));
        tab_a.push_back(mk(0,0,NO,0,8'h00,8'h00, 0,8'h81,0,0,0));
        tab_a.push_back(mk(0,1,RT,0,8'h00,8'h7F, 1,8'h11,0,1,0));
        tab_a.push_back(mk(1,0,NO,0,8'h00,8'h00, 0,8'h11,0,1,0));
        tab_a.push_back(mk(1,1,J ,0,8'h60,8'h0F, 1,8'h60,0,1,0));
        tab_a.push_back(mk(0,0,J ,0,8'h70,8'h5E, 0,8'h61,0,1,0));
        tab_a.push_back(mk(0,1,J|CL,0,8'h90,8'h5F,0,8'h62,1,1,0));
        tab_a.push_back(mk(0,1,RT,0,8'h00,8'h60, 0,8'h63,1,1,0));

        tab_b.push_back(mk(0,1,CL,0,8'hA0,8'h01, 1,8'hA0,0,0,0));
        tab_b.push_back(mk(0,1,CL,0,8'hA1,8'h02, 1,8'hA1,0,0,0));
        tab_b.push_back(mk(0,1,CL,0,8'hA2,8'h03, 1,8'hA2,0,0,0));
        tab_b.push_back(mk(0,1,CL,0,8'hA3,8'h04, 1,8'hA3,0,0,1));
        tab_b.push_back(mk(0,1,CL,0,8'hA4,8'h05, 1,8'hA4,1,0,1));
        tab_b.push_back(mk(0,1,RT,0,8'h00,8'hC0, 1,8'h05,1,0,0));
        tab_b.push_back(mk(0,1,RT,0,8'h00,8'hC1, 1,8'h04,1,0,0));
        tab_b.push_back(mk(0,1,RT,0,8'h00,8'hC2, 1,8'h03,1,0,0));
        tab_b.push_back(mk(0,1,RT,0,8'h00,8'hC3, 1,8'h02,1,1,0));
        tab_b.push_back(mk(0,1,RT,0,8'h00,8'hC4, 0,8'h03,1,1,0));
        tab_b.push_back(mk(1,0,NO,0,8'h00,8'h00, 0,8'h03,1,1,0));

        // Power-on reset with a jump presented: flush must stay low while rst is high.
        rst = 1'b1;
        drive(0, 1, J, 0, 8'h55, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc",    int'(pc),        0);
        chk("rst_flush", int'(flush),     0);
        chk("rst_empty", int'(ras_empty), 1);
        chk("rst_full",  int'(ras_full),  0);
        chk("rst_err",   int'(err),       0);
        drive(0, 0, NO, 0, 8'h00, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < tab_a.size(); i++) begin
            apply(tab_a[i], i);
        end

        // Mid-run async reset: state clears without waiting for a clock edge.
        drive(0, 1, J, 0, 8'h77, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_pc",    int'(pc),        0);
        chk("mid_rst_err",   int'(err),       0);
        chk("mid_rst_flush", int'(flush),     0);
        chk("mid_rst_empty", int'(ras_empty), 1);
        @(negedge clk);
        drive(0, 0, NO, 0, 8'h00, 8'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_pc", int'(pc), 1);
        // Re-align to pc=0 for the nested-call table.
        drive(0, 1, J, 0, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        chk("realign_pc", int'(pc), 0);

        for (int i = 0; i < tab_b.size(); i++) begin
            apply(tab_b[i], 100 + i);
        end

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
